// File: rtl/time_setter.sv
// ----------------------------------------------------------------------------
// time_setter
//   Front-end writer for the clock's date/time preset bus. Each of the five
//   navigation buttons is synchronised and debounced into a one-clock press
//   pulse. Up/down also auto-repeat while held in EDIT. A two-state
//   RUN/EDIT FSM selects a field and steps it with wrap-around. The day is
//   clamped whenever the month or year changes.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   up, down, left, right, middle   raw (unsynchronised) button levels
//   year_d  [14:0]                  preset year, YEAR_MIN..YEAR_MAX
//   month_d [3:0]                   preset month, 1..12
//   day_d   [4:0]                   preset day, 1..days in month
//   hour_d  [5:0]                   preset hour, 0..23
//   min_d   [5:0]                   preset minute, 0..59
//   sec_d   [5:0]                   preset second, 0..59
//   week_s  [3:0]                   preset weekday, 1..7
//   mode    [3:0]                   0 = RUN, 1 = EDIT (core loads preset bus)
//   field   [2:0]                   selected field 0 yr .. 6 wk
// ----------------------------------------------------------------------------
module time_setter #(
   parameter logic [19:0] DEB_CYCLES    = 20'd500000,
   parameter logic [25:0] HOLD_CYCLES   = 26'd50000000,
   parameter logic [25:0] REPEAT_CYCLES = 26'd10000000,
   parameter logic [14:0] YEAR_MIN      = 15'd2000,
   parameter logic [14:0] YEAR_MAX      = 15'd2099
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        up,
   input  logic        down,
   input  logic        left,
   input  logic        right,
   input  logic        middle,
   output logic [14:0] year_d,
   output logic [3:0]  month_d,
   output logic [4:0]  day_d,
   output logic [5:0]  hour_d,
   output logic [5:0]  min_d,
   output logic [5:0]  sec_d,
   output logic [3:0]  week_s,
   output logic [3:0]  mode,
   output logic [2:0]  field
);

   localparam logic [0:0] RUN  = 1'b0;
   localparam logic [0:0] EDIT = 1'b1;

   logic [0:0]  state_reg, state_next;
   logic [2:0]  field_reg, field_next;
   logic [14:0] year_reg, year_next;
   logic [3:0]  month_reg, month_next;
   logic [4:0]  day_reg, day_next;
   logic [5:0]  hour_reg, hour_next;
   logic [5:0]  min_reg, min_next;
   logic [5:0]  sec_reg, sec_next;
   logic [3:0]  week_reg, week_next;

   // Bit order: 0 up, 1 down, 2 left, 3 right, 4 middle.
   logic [4:0] btn_raw;
   logic [4:0] press;
   logic [1:0] rep;

   assign btn_raw = {middle, right, left, down, up};

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_btn
         logic        sync1_reg, sync2_reg, deb_reg, press_reg;
         logic [19:0] cnt_reg;

         // The debounced level follows the synced level only after it has
         // differed for DEB_CYCLES consecutive clocks; a press pulse is
         // raised in the same edge that the level goes high.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               deb_reg   <= 1'b0;
               press_reg <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               sync1_reg <= btn_raw[gi];
               sync2_reg <= sync1_reg;
               press_reg <= 1'b0;
               if (sync2_reg != deb_reg) begin
                  if (cnt_reg == DEB_CYCLES - 20'd1) begin
                     deb_reg   <= sync2_reg;
                     press_reg <= sync2_reg;
                     cnt_reg   <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + 20'd1;
                  end
               end else begin
                  cnt_reg <= '0;
               end
            end
         end

         assign press[gi] = press_reg;

         if (gi < 2) begin : g_rep
            logic [25:0] timer_reg;
            logic        phase_reg;   // 0: waiting out the hold, 1: repeating
            logic        rep_reg;

            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  timer_reg <= '0;
                  phase_reg <= 1'b0;
                  rep_reg   <= 1'b0;
               end else begin
                  rep_reg <= 1'b0;
                  if (!deb_reg || state_reg != EDIT) begin
                     timer_reg <= '0;
                     phase_reg <= 1'b0;
                  end else if (!phase_reg) begin
                     if (timer_reg == HOLD_CYCLES - 26'd1) begin
                        rep_reg   <= 1'b1;
                        timer_reg <= '0;
                        phase_reg <= 1'b1;
                     end else begin
                        timer_reg <= timer_reg + 26'd1;
                     end
                  end else begin
                     if (timer_reg == REPEAT_CYCLES - 26'd1) begin
                        rep_reg   <= 1'b1;
                        timer_reg <= '0;
                     end else begin
                        timer_reg <= timer_reg + 26'd1;
                     end
                  end
               end
            end

            assign rep[gi] = rep_reg;
         end
      end
   endgenerate

   function automatic logic is_leap(input logic [14:0] y);
      return (y[1:0] == 2'd0) &&
             (((y % 15'd100) != 15'd0) || ((y % 15'd400) == 15'd0));
   endfunction

   function automatic logic [4:0] days_in_month(input logic [3:0] m,
                                                input logic [14:0] y);
      case (m)
         4'd2:                    return is_leap(y) ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
         default:                 return 5'd31;
      endcase
   endfunction

   logic       step_up, step_dn;
   logic [4:0] dim_cur, dim_new;

   assign step_up = press[0] | rep[0];
   assign step_dn = press[1] | rep[1];
   assign dim_cur = days_in_month(month_reg, year_reg);

   always_comb begin
      state_next = state_reg;
      field_next = field_reg;
      year_next  = year_reg;
      month_next = month_reg;
      day_next   = day_reg;
      hour_next  = hour_reg;
      min_next   = min_reg;
      sec_next   = sec_reg;
      week_next  = week_reg;

      if (state_reg == RUN) begin
         if (press[4]) begin
            state_next = EDIT;
            field_next = 3'd0;
         end
      end else begin
         // Priority chain: only the highest-priority pulse in a clock acts.
         if (press[4]) begin
            state_next = RUN;
         end else if (press[3]) begin
            field_next = (field_reg == 3'd6) ? 3'd0 : field_reg + 3'd1;
         end else if (press[2]) begin
            field_next = (field_reg == 3'd0) ? 3'd6 : field_reg - 3'd1;
         end else if (step_up || step_dn) begin
            // step_up wins when both fire together.
            case (field_reg)
               3'd0: year_next = step_up
                  ? ((year_reg == YEAR_MAX) ? YEAR_MIN : year_reg + 15'd1)
                  : ((year_reg == YEAR_MIN) ? YEAR_MAX : year_reg - 15'd1);
               3'd1: month_next = step_up
                  ? ((month_reg == 4'd12) ? 4'd1 : month_reg + 4'd1)
                  : ((month_reg == 4'd1) ? 4'd12 : month_reg - 4'd1);
               3'd2: day_next = step_up
                  ? ((day_reg >= dim_cur) ? 5'd1 : day_reg + 5'd1)
                  : ((day_reg <= 5'd1) ? dim_cur : day_reg - 5'd1);
               3'd3: hour_next = step_up
                  ? ((hour_reg >= 6'd23) ? 6'd0 : hour_reg + 6'd1)
                  : ((hour_reg == 6'd0) ? 6'd23 : hour_reg - 6'd1);
               3'd4: min_next = step_up
                  ? ((min_reg >= 6'd59) ? 6'd0 : min_reg + 6'd1)
                  : ((min_reg == 6'd0) ? 6'd59 : min_reg - 6'd1);
               3'd5: sec_next = step_up
                  ? ((sec_reg >= 6'd59) ? 6'd0 : sec_reg + 6'd1)
                  : ((sec_reg == 6'd0) ? 6'd59 : sec_reg - 6'd1);
               default: week_next = step_up
                  ? ((week_reg >= 4'd7) ? 4'd1 : week_reg + 4'd1)
                  : ((week_reg <= 4'd1) ? 4'd7 : week_reg - 4'd1);
            endcase
         end
      end

      // Clamp the day against the month/year being written this cycle.
      dim_new = days_in_month(month_next, year_next);
      if (day_next > dim_new)
         day_next = dim_new;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= RUN;
         field_reg <= 3'd0;
         year_reg  <= YEAR_MIN;
         month_reg <= 4'd1;
         day_reg   <= 5'd1;
         hour_reg  <= 6'd0;
         min_reg   <= 6'd0;
         sec_reg   <= 6'd0;
         week_reg  <= 4'd1;
      end else begin
         state_reg <= state_next;
         field_reg <= field_next;
         year_reg  <= year_next;
         month_reg <= month_next;
         day_reg   <= day_next;
         hour_reg  <= hour_next;
         min_reg   <= min_next;
         sec_reg   <= sec_next;
         week_reg  <= week_next;
      end
   end

   assign year_d  = year_reg;
   assign month_d = month_reg;
   assign day_d   = day_reg;
   assign hour_d  = hour_reg;
   assign min_d   = min_reg;
   assign sec_d   = sec_reg;
   assign week_s  = week_reg;
   assign mode    = {3'b000, state_reg};
   assign field   = field_reg;

endmodule
